// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Covers the sequencing states, the forwarding select encodings and the all-zero bubble control word.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERROR   = 2'd2
    } state_e;

    // EX operand source selects.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       alusrc;
        logic       regdst;
        logic [1:0] aluop;
    } ctrl_t;

    // A flushed pipeline register loads this control word, which makes it a bubble.
    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX-stage forwarding compare.
// A pending write in MEM wins over one in WB, and register 0 is never forwarded.
module fwd_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_writereg,
    input  logic [4:0] wb_writereg,
    input  logic       mem_regwrite,
    input  logic       wb_regwrite,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       m_we,
        input logic [4:0] m_rd,
        input logic       w_we,
        input logic [4:0] w_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (m_we && (m_rd != 5'd0) && (m_rd == src))
            sel = FWD_MEM;
        else if (w_we && (w_rd != 5'd0) && (w_rd == src))
            sel = FWD_WB;
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_regwrite, mem_writereg, wb_regwrite, wb_writereg);
        fwd_b = fwd_sel(ex_rt, mem_regwrite, mem_writereg, wb_regwrite, wb_writereg);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline.
// Handles load-use stalls, taken-branch flushes and dmem waits with a timeout, and keeps stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_memtoreg,
    input  logic [4:0]       mem_writereg,
    input  logic [4:0]       wb_writereg,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             mem_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             pc_src,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [7:0]       wait_inc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    fwd_unit u_fwd (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_writereg (mem_writereg),
        .wb_writereg  (wb_writereg),
        .mem_regwrite (mem_regwrite),
        .wb_regwrite  (wb_regwrite),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    assign load_use = ex_memtoreg && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign wait_inc = wait_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        pc_src       = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        dmem_req     = 1'b0;
        case (state_q)
            RUN: begin
                dmem_req = mem_access;
                if (mem_access && !dmem_ready) begin
                    // MEM/WB keeps loading so the datapath can clock a gated-regwrite bubble into WB.
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    wait_d    = 8'd1;
                    state_d   = (TIMEOUT <= 8'd1) ? ERROR : MEMWAIT;
                end else if (mem_branch_taken) begin
                    pc_src       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MEMWAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    wait_d  = 8'd0;
                    state_d = RUN;
                end else begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                    wait_d    = wait_inc;
                    if (wait_inc >= TIMEOUT)
                        state_d = ERROR;
                end
            end
            ERROR: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
            end
            default: begin
                state_d = RUN;
                wait_d  = 8'd0;
            end
        endcase
    end

    // Counters saturate rather than wrap so long runs never read as small values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (state_q != ERROR) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (pc_src && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_q      <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign err       = (state_q == ERROR);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Uses 4-bit counters so that saturation is reachable in a short run.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, mem_writereg, wb_writereg;
    logic          ex_memtoreg, mem_regwrite, wb_regwrite;
    logic          mem_branch_taken, mem_access, dmem_ready;
    logic          dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          pc_src, if_id_flush, id_ex_flush, ex_mem_flush, err;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .ex_rs            (ex_rs),
        .ex_rt            (ex_rt),
        .ex_memtoreg      (ex_memtoreg),
        .mem_writereg     (mem_writereg),
        .wb_writereg      (wb_writereg),
        .mem_regwrite     (mem_regwrite),
        .wb_regwrite      (wb_regwrite),
        .mem_branch_taken (mem_branch_taken),
        .mem_access       (mem_access),
        .dmem_ready       (dmem_ready),
        .dmem_req         (dmem_req),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .id_ex_en         (id_ex_en),
        .ex_mem_en        (ex_mem_en),
        .mem_wb_en        (mem_wb_en),
        .pc_src           (pc_src),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .err              (err),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    logic [4:0] en;
    logic [2:0] fl;
    assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl = {if_id_flush, id_ex_flush, ex_mem_flush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
        mem_writereg = 5'd0; wb_writereg = 5'd0;
        ex_memtoreg = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        mem_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic set_load_use();
        ex_memtoreg = 1'b1; ex_rt = 5'd2; id_rs = 5'd2; id_rt = 5'd1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #12;
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_en", 32'(en), 32'h1f);
        chk("rst_flush", 32'(fl), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        reset = 1'b0;
        tick();

        // lw r2 in EX, add r3,r2,r1 in ID
        set_load_use();
        #1;
        chk("lu_en", 32'(en), 32'b00111);
        chk("lu_flush", 32'(fl), 32'b010);
        chk("lu_pcsrc", 32'(pc_src), 32'd0);
        tick();
        idle();
        ex_rs = 5'd2; ex_rt = 5'd1; wb_regwrite = 1'b1; wb_writereg = 5'd2;
        #1;
        chk("lu_next_en", 32'(en), 32'h1f);
        chk("lu_next_fwd_a", 32'(fwd_a), 32'b01);
        chk("lu_next_fwd_b", 32'(fwd_b), 32'b00);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        idle();
        ex_memtoreg = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("lu_r0_en", 32'(en), 32'h1f);

        // Taken branch overrides a simultaneous load-use
        tick();
        do_reset();
        set_load_use();
        mem_branch_taken = 1'b1;
        #1;
        chk("br_pcsrc", 32'(pc_src), 32'd1);
        chk("br_flush", 32'(fl), 32'b111);
        chk("br_en", 32'(en), 32'h1f);
        tick();
        idle();
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Store waiting 3 cycles on dmem
        do_reset();
        mem_access = 1'b1;
        #1;
        chk("mw1_en", 32'(en), 32'b00001);
        chk("mw1_req", 32'(dmem_req), 32'd1);
        tick();
        chk("mw2_en", 32'(en), 32'd0);
        chk("mw2_req", 32'(dmem_req), 32'd1);
        tick();
        chk("mw3_en", 32'(en), 32'd0);
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("mw_done_en", 32'(en), 32'h1f);
        chk("mw_done_req", 32'(dmem_req), 32'd1);
        tick();
        idle();
        #1;
        chk("mw_run_en", 32'(en), 32'h1f);
        chk("mw_run_req", 32'(dmem_req), 32'd0);
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);
        mem_access = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("mw_fast_en", 32'(en), 32'h1f);
        chk("mw_fast_req", 32'(dmem_req), 32'd1);
        tick();
        chk("mw_fast_stall_cnt", 32'(stall_cnt), 32'd3);

        // dmem never ready: timeout after 15 cycles
        do_reset();
        mem_access = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("to_pre_err", 32'(err), 32'd0);
            tick();
        end
        #1;
        chk("to_err", 32'(err), 32'd1);
        chk("to_en", 32'(en), 32'd0);
        chk("to_req", 32'(dmem_req), 32'd0);
        chk("to_stall_cnt", 32'(stall_cnt), 32'd15);
        dmem_ready = 1'b1;
        tick();
        chk("to_sticky", 32'(err), 32'd1);
        chk("to_sticky_cnt", 32'(stall_cnt), 32'd15);
        reset = 1'b1;
        #1;
        chk("to_rst_err", 32'(err), 32'd0);
        chk("to_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b0;

        // Reset taken while in MEMWAIT
        idle();
        mem_access = 1'b1;
        tick();
        tick();
        chk("rm_wait_en", 32'(en), 32'd0);
        reset = 1'b1;
        #1;
        chk("rm_run_en", 32'(en), 32'b00001);
        chk("rm_stall_cnt", 32'(stall_cnt), 32'd0);
        idle();
        reset = 1'b0;

        // Forwarding priority and r0 exclusion
        mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        mem_writereg = 5'd5; wb_writereg = 5'd5; ex_rs = 5'd5; ex_rt = 5'd7;
        #1;
        chk("fw_both_a", 32'(fwd_a), 32'b10);
        chk("fw_none_b", 32'(fwd_b), 32'b00);
        mem_writereg = 5'd0;
        #1;
        chk("fw_wb_a", 32'(fwd_a), 32'b01);
        mem_writereg = 5'd5; mem_regwrite = 1'b0;
        #1;
        chk("fw_memoff_a", 32'(fwd_a), 32'b01);
        mem_regwrite = 1'b1; mem_writereg = 5'd0; wb_writereg = 5'd0; ex_rs = 5'd0;
        #1;
        chk("fw_r0_a", 32'(fwd_a), 32'b00);
        mem_writereg = 5'd7; wb_writereg = 5'd7;
        #1;
        chk("fw_mem_b", 32'(fwd_b), 32'b10);

        // Counter saturation
        tick();
        do_reset();
        set_load_use();
        for (int i = 0; i < 18; i++) tick();
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        tick();
        chk("sat_stall_hold", 32'(stall_cnt), 32'd15);
        idle();
        mem_branch_taken = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        chk("sat_flush_cnt", 32'(flush_cnt), 32'd15);
        chk("sat_stall_keep", 32'(stall_cnt), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
